mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Unified instruction/data memory for the multicycle MIPS core. It is the responder side of the memory interface that the main control FSM drives through its IorD, memwrite and IRwrite sequencing.
- Accepts one word read or write request at a time. Inserts a programmable number of wait states, then returns a one-cycle response.
- Sits between the datapath address/write-data mux and the instruction/data registers.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, 2..1024.
- LATENCY, 2, wait cycles between request accept and response; 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets.
- req_valid  in  1  request strobe; sampled only while req_ready=1.
- req_write  in  1  1=write, 0=read; sampled with req_valid.
- addr  in  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2].
- wdata  in  32  write data; sampled with req_valid.
- req_ready  out  1  1 while idle and able to accept a request.
- rsp_valid  out  1  one-cycle pulse marking completion of the request.
- rdata  out  32  read data; valid only while rsp_valid=1.
- err  out  1  error flag; valid only while rsp_valid=1.

Behaviour:
- Reset values: req_ready=1 on the first cycle after reset; rsp_valid=0, rdata=0, err=0; FSM=IDLE; wait counter=0. Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - req_valid=1 accepts the request: latch req_write, addr and wdata.
  - If LATENCY==0, go to RESP. Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; go to RESP when counter==0.
- RESP:
  - rsp_valid=1 for exactly this cycle.
  - Read: rdata=mem[word index]. Write: mem[word index]<=wdata at this clock edge, rdata=0.
  - Next state is IDLE. req_ready=0 during RESP.
- Latency: rsp_valid is asserted exactly LATENCY+1 cycles after the accept edge. With LATENCY=0, the response comes on the next cycle.
- Requests are not queued: req_valid while req_ready=0 is ignored and does not affect the latched request. The earliest next accept is the cycle after RESP, so back-to-back requests take LATENCY+2 cycles each.
- There is no response backpressure. The requester must capture rdata during the rsp_valid cycle.
- outputs rdata and err are forced to 0 whenever rsp_valid=0.
- Read-after-write: a read accepted after a write response returns the newly written value.
- Reset mid-operation: a reset in WAIT or RESP abandons the transaction. No memory write occurs if reset coincides with the RESP edge. The FSM returns to IDLE and no rsp_valid pulse is produced.
- Address wrap: see the optional feature below.

Optional Feature:
- Macro: MEMRESP_ERR_EN.
- Defined:
  - In RESP, err=1 if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
  - An erroring write does not modify memory. An erroring read returns rdata=0.
  - Latency is unchanged.
- Undefined:
  - err is tied to 0.
  - addr[1:0] is ignored.
  - The word index wraps modulo DEPTH_WORDS (upper address bits are ignored).

Test Plan:
- Reset, then write wdata=0x12345678 to addr=0x10, then read addr=0x10 (LATENCY=2) -> req_ready drops the cycle after accept; rsp_valid on the 3rd edge after each accept; read returns rdata=0x12345678 with err=0.
- LATENCY=0: write 0xDEADBEEF to addr=0x0, then an immediate read of 0x0 -> each rsp_valid comes 1 cycle after accept; rdata=0xDEADBEEF; next accept possible 2 cycles after the previous accept.
- req_valid held high with a different addr/wdata throughout WAIT -> ignored; the response reflects only the first request; exactly one rsp_valid pulse per accept.
- Assert reset=0 in the WAIT cycle of a write of 0xCAFEF00D to addr=0x20 -> no rsp_valid; later read of 0x20 returns its prior value; req_ready=1 on the first cycle after reset.
- With MEMRESP_ERR_EN: read addr=0x13 and read addr=0x100 (DEPTH_WORDS=64) -> rsp_valid with err=1 and rdata=0; write to 0x100 leaves mem[0] unchanged.
- Without MEMRESP_ERR_EN: write 0xA5A5A5A5 to addr=0x100, read addr=0x0 -> rdata=0xA5A5A5A5 (wrap), err=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory for the multicycle MIPS core.
// Accepts one word request at a time, waits LATENCY cycles, and then gives a
// single-cycle response. There is no queueing and no response backpressure.
// Optional feature macro: MEMRESP_ERR_EN. When it is defined, misaligned or
// out-of-range addresses raise err. When it is undefined, err is tied to 0 and
// the word index wraps modulo DEPTH_WORDS.
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LOAD_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [3:0]     cnt_r;
    logic [3:0]     next_cnt_s;
    logic           req_write_r;
    logic [31:0]    addr_r;
    logic [31:0]    wdata_r;
    logic           accept_s;
    logic           sel_write_s;
    logic [31:0]    sel_addr_s;
    logic [AW-1:0]  sel_idx_s;
    logic           sel_err_s;
    logic [31:0]    mem [DEPTH_WORDS];

`ifdef MEMRESP_ERR_EN
    // Address error: the address is misaligned or lies beyond the last stored word.
    function automatic logic addr_error(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction
`endif

    // The request being acted on: the live inputs on the accept cycle, otherwise the latched copy.
    assign accept_s    = (state_r == ST_IDLE) && req_valid;
    assign sel_write_s = accept_s ? req_write : req_write_r;
    assign sel_addr_s  = accept_s ? addr : addr_r;
    assign sel_idx_s   = sel_addr_s[AW+1:2];

`ifdef MEMRESP_ERR_EN
    assign sel_err_s = addr_error(sel_addr_s);
`else
    logic addr_unused_s;
    assign sel_err_s     = 1'b0;
    assign addr_unused_s = ^{sel_addr_s[31:AW+2], sel_addr_s[1:0]};
`endif

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Next-state logic: IDLE accepts a request, WAIT counts down, RESP lasts one cycle.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_WAIT;
                        next_cnt_s   = LOAD_CNT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = 4'd0;
            end
        endcase
    end

    // Latch the request on accept. Requests that arrive while busy are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_write_r <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
        end else if (accept_s) begin
            req_write_r <= req_write;
            addr_r      <= addr;
            wdata_r     <= wdata;
        end
    end

    // Registered outputs, decoded from the next state. rdata and err stay at 0 outside RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            req_ready <= (next_state_s == ST_IDLE);
            rsp_valid <= (next_state_s == ST_RESP);
            if (next_state_s == ST_RESP) begin
                err   <= sel_err_s;
                rdata <= (!sel_write_s && !sel_err_s) ? mem[sel_idx_s] : 32'd0;
            end else begin
                err   <= 1'b0;
                rdata <= 32'd0;
            end
        end
    end

    // Memory write on the edge that ends RESP. It is suppressed by reset or an address error.
    always_ff @(posedge clk) begin
        if (reset && (state_r == ST_RESP) && req_write_r && !err) begin
            mem[addr_r[AW+1:2]] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Instance A uses LATENCY=2 and instance B uses LATENCY=0.
// The bench runs table vectors, hand-written reset/latency sequences, and
// randomized traffic. All traffic is checked against a word-array model.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_write(a_req_write),
        .addr(a_addr), .wdata(a_wdata), .req_ready(a_req_ready), .rsp_valid(a_rsp_valid),
        .rdata(a_rdata), .err(a_err)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_write(b_req_write),
        .addr(b_addr), .wdata(b_wdata), .req_ready(b_req_ready), .rsp_valid(b_rsp_valid),
        .rdata(b_rdata), .err(b_err)
    );

    function automatic logic model_err(input logic [31:0] a);
`ifdef MEMRESP_ERR_EN
        return (a % 32'd4 != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(DEPTH));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on instance A, with protocol and latency checks.
    task automatic txn_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit noise, output logic [31:0] rd, output logic e);
        int n;
        int lat;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_write = w;
        a_addr      = a;
        a_wdata     = d;
        @(posedge clk);
        @(negedge clk);
        chk("ready_drop_after_accept", 32'(a_req_ready), 32'd0);
        if (noise) begin
            a_req_write = ~w;
            a_addr      = $urandom;
            a_wdata     = $urandom;
        end else begin
            a_req_valid = 1'b0;
        end
        lat = 1;
        while (a_rsp_valid !== 1'b1 && lat < 40) begin
            chk("quiet_outputs", a_rdata | {31'd0, a_err}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency_edges", 32'(lat), 32'(LAT_A + 1));
        rd = a_rdata;
        e  = a_err;
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("single_pulse", 32'(a_rsp_valid), 32'd0);
        chk("ready_after_resp", 32'(a_req_ready), 32'd1);
        if (w && !model_err(a)) model_mem[model_idx(a)] = d;
    endtask

    task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input bit noise);
        logic [31:0] rd;
        logic        e;
        logic [31:0] exp_rd;
        logic        exp_e;
        exp_e  = model_err(a);
        exp_rd = (w || exp_e) ? 32'd0 : model_mem[model_idx(a)];
        txn_a(w, a, d, noise, rd, e);
        chk("model_rdata", rd, exp_rd);
        chk("model_err", 32'(e), 32'(exp_e));
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] old;
        int          n;

        vecs[0] = '{1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0};
        vecs[2] = '{1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0};
`ifdef MEMRESP_ERR_EN
        vecs[3] = '{1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0};
        vecs[5] = '{1'b0, 32'h13, 32'h0, 32'h0, 1'b1};
        vecs[6] = '{1'b0, 32'h100, 32'h0, 32'h0, 1'b1};
        vecs[7] = '{1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0};
`else
        vecs[3] = '{1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0};
        vecs[5] = '{1'b0, 32'h103, 32'h0, 32'hA5A5A5A5, 1'b0};
        vecs[6] = '{1'b1, 32'hFC, 32'h0BADCAFE, 32'h0, 1'b0};
        vecs[7] = '{1'b0, 32'hFFFFFFFC, 32'h0, 32'h0BADCAFE, 1'b0};
`endif

        reset = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("reset_ready_a", 32'(a_req_ready), 32'd1);
        chk("reset_rsp_valid_a", 32'(a_rsp_valid), 32'd0);
        chk("reset_rdata_a", a_rdata, 32'd0);
        chk("reset_err_a", 32'(a_err), 32'd0);
        chk("reset_ready_b", 32'(b_req_ready), 32'd1);

        // LATENCY=0: a write, then a read accepted two cycles after the write.
        b_req_valid = 1'b1; b_req_write = 1'b1; b_addr = 32'h0; b_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        chk("lat0_write_rsp", 32'(b_rsp_valid), 32'd1);
        chk("lat0_write_rdata", b_rdata, 32'd0);
        chk("lat0_ready_in_resp", 32'(b_req_ready), 32'd0);
        b_req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("lat0_idle_rsp", 32'(b_rsp_valid), 32'd0);
        chk("lat0_idle_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("lat0_read_rsp", 32'(b_rsp_valid), 32'd1);
        chk("lat0_read_rdata", b_rdata, 32'hDEADBEEF);
        chk("lat0_read_err", 32'(b_err), 32'd0);
        b_req_valid = 1'b0;

        // Table vectors on LATENCY=2. Odd entries keep req_valid high with junk while busy.
        for (int i = 0; i < 8; i++) begin
            txn_a(vecs[i].w, vecs[i].addr, vecs[i].wdata, (i % 2) == 1, rd, e);
            chk("vec_rdata", rd, vecs[i].exp_rdata);
            chk("vec_err", 32'(e), 32'(vecs[i].exp_err));
        end

        // Preload every word so the model knows the whole memory.
        for (int i = 0; i < DEPTH; i++) begin
            model_txn(1'b1, 32'(i * 4), $urandom, 1'b0);
        end

        // Randomized mixed traffic.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
            model_txn(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset during WAIT abandons the write and produces no response.
        a_req_valid = 1'b1; a_req_write = 1'b1; a_addr = 32'h20; a_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_wait_ready", 32'(a_req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rst_wait_no_rsp", 32'(a_rsp_valid), 32'd0);
            @(negedge clk);
        end
        model_txn(1'b0, 32'h20, 32'h0, 1'b0);

        // Reset coinciding with the RESP edge suppresses the memory write.
        old = model_mem[9];
        a_req_valid = 1'b1; a_req_write = 1'b1; a_addr = 32'h24; a_wdata = ~old;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 0;
        while (a_rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_resp_reached", 32'(a_rsp_valid), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_resp_no_rsp", 32'(a_rsp_valid), 32'd0);
        chk("rst_resp_ready", 32'(a_req_ready), 32'd1);
        txn_a(1'b0, 32'h24, 32'h0, 1'b0, rd, e);
        chk("rst_resp_mem_kept", rd, old);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
